ps2_host_tx: RTL

- Host-to-device PS/2 byte transmitter: the send half of the PS/2 link that the mouse/keyboard front-ends drive via cmd/dat/ready.
- Performs the clock-inhibit / request-to-send sequence, shifts 8 data bits + odd parity + stop on device-generated clocks, samples the device ACK, reports done/error.
- Drives the PS/2 lines only through open-drain enables; top level builds the tristates (oe=1 -> line 0, else Z).

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_sync_edge.sv | 33 +++
 rtl/ps2_host_tx.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// PS/2 host-side shared types: FSM state encoding, default cycle counts at 25 MHz, parity helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        FINISH
    } ps2_state_t;

    localparam int INHIBIT_CYC_DEF   = 2500;
    localparam int REQ_CYC_DEF       = 25;
    localparam int FIRST_TMO_CYC_DEF = 375000;
    localparam int EDGE_TMO_CYC_DEF  = 50000;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// PS/2 line synchronizer: 2-FF sync of clock and data, falling-edge strobe on the synced clock.
// Latency: 2 cycles to dat_sync, clk_fall asserted 2 cycles after the line drops.
// Backpressure: none, free-running.
module ps2_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic ps_clk_i,
    input  logic ps_dat_i,
    output logic clk_fall,
    output logic dat_sync
);

    logic [1:0] clk_ff;
    logic [1:0] dat_ff;
    logic       clk_prev;

    // Preset high so releasing reset on an idle (pulled-up) bus never looks like an edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_ff   <= 2'b11;
            dat_ff   <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], ps_clk_i};
            dat_ff   <= {dat_ff[0], ps_dat_i};
            clk_prev <= clk_ff[1];
        end
    end

    assign clk_fall = clk_prev & ~clk_ff[1];
    assign dat_sync = dat_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte sender: inhibit/request, 8 data + odd parity + stop on device clocks, ACK check.
// Latency: INHIBIT_CYC + REQ_CYC + 11 device clocks to done; optional PS2_TX_RETRY_EN retries twice on failure.
// Backpressure: cmd taken only while ready=1; cmd during a transfer is dropped.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC   = INHIBIT_CYC_DEF,
    parameter int REQ_CYC       = REQ_CYC_DEF,
    parameter int FIRST_TMO_CYC = FIRST_TMO_CYC_DEF,
    parameter int EDGE_TMO_CYC  = EDGE_TMO_CYC_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps_clk_i,
    input  logic       ps_dat_i,
    output logic       ps_clk_oe,
    output logic       ps_dat_oe,
    input  logic       cmd,
    input  logic [7:0] dat,
    output logic       ready,
    output logic       done,
    output logic       err,
    output logic       busy
);

    localparam int DLY_MAX = (INHIBIT_CYC > REQ_CYC) ? INHIBIT_CYC : REQ_CYC;
    localparam int DW      = $clog2(DLY_MAX + 1);
    localparam int TW      = $clog2(FIRST_TMO_CYC + 1);

    localparam logic [DW-1:0] INH_LD   = DW'(INHIBIT_CYC - 1);
    localparam logic [DW-1:0] REQ_LD   = DW'(REQ_CYC - 1);
    localparam logic [TW-1:0] FIRST_LD = TW'(FIRST_TMO_CYC);
    localparam logic [TW-1:0] EDGE_LD  = TW'(EDGE_TMO_CYC);

    ps2_state_t    state_q, state_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic [3:0]    bit_q, bit_d;
    logic [DW-1:0] dly_q, dly_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          dat_oe_q, dat_oe_d;
    logic          fail_q, fail_d;
    logic          clk_fall, dat_sync;
    logic          expire, restart, can_retry;

    ps2_sync_edge u_sync (
        .clock    (clock),
        .reset    (reset),
        .ps_clk_i (ps_clk_i),
        .ps_dat_i (ps_dat_i),
        .clk_fall (clk_fall),
        .dat_sync (dat_sync)
    );

`ifdef PS2_TX_RETRY_EN
    logic [1:0] retry_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                       retry_q <= 2'd0;
        else if (state_q == IDLE && cmd) retry_q <= 2'd0;
        else if (restart)                retry_q <= retry_q + 2'd1;
    end

    assign can_retry = (retry_q != 2'd2);
`else
    assign can_retry = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            data_q   <= 8'h00;
            par_q    <= 1'b0;
            bit_q    <= 4'd0;
            dly_q    <= '0;
            tmo_q    <= '0;
            dat_oe_q <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            par_q    <= par_d;
            bit_q    <= bit_d;
            dly_q    <= dly_d;
            tmo_q    <= tmo_d;
            dat_oe_q <= dat_oe_d;
            fail_q   <= fail_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        par_d    = par_q;
        bit_d    = bit_q;
        dly_d    = dly_q;
        tmo_d    = tmo_q;
        dat_oe_d = dat_oe_q;
        fail_d   = fail_q;
        expire   = 1'b0;
        restart  = 1'b0;
        done     = 1'b0;
        err      = 1'b0;

        case (state_q)
            IDLE: begin
                dat_oe_d = 1'b0;
                if (cmd) begin
                    data_d  = dat;
                    par_d   = odd_parity(dat);
                    fail_d  = 1'b0;
                    dly_d   = INH_LD;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (dly_q == '0) begin
                    dly_d    = REQ_LD;
                    dat_oe_d = 1'b1;
                    state_d  = REQ;
                end else begin
                    dly_d = dly_q - DW'(1);
                end
            end
            REQ: begin
                if (dly_q == '0) begin
                    bit_d   = 4'd0;
                    tmo_d   = FIRST_LD;
                    state_d = SHIFT;
                end else begin
                    dly_d = dly_q - DW'(1);
                end
            end
            SHIFT: begin
                // Start bit stays on the line from REQ; each fall presents the next bit.
                if (clk_fall) begin
                    tmo_d = EDGE_LD;
                    bit_d = bit_q + 4'd1;
                    if (!bit_q[3]) begin
                        dat_oe_d = ~data_q[bit_q[2:0]];
                    end else if (bit_q == 4'd8) begin
                        dat_oe_d = ~par_q;
                    end else begin
                        dat_oe_d = 1'b0;
                        state_d  = ACK;
                    end
                end else if (tmo_q == '0) begin
                    expire = 1'b1;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
            end
            ACK: begin
                if (clk_fall) begin
                    if (dat_sync && can_retry) begin
                        restart = 1'b1;
                    end else begin
                        fail_d  = dat_sync;
                        state_d = FINISH;
                    end
                end else if (tmo_q == '0) begin
                    expire = 1'b1;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
            end
            FINISH: begin
                done    = 1'b1;
                err     = fail_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (expire) begin
            dat_oe_d = 1'b0;
            if (can_retry) begin
                restart = 1'b1;
            end else begin
                done    = 1'b1;
                err     = 1'b1;
                state_d = IDLE;
            end
        end

        if (restart) begin
            dly_d    = INH_LD;
            dat_oe_d = 1'b0;
            state_d  = INHIBIT;
        end
    end

    // Data is masked on the expiry cycle so both lines are free the moment a timeout fires.
    assign ps_clk_oe = (state_q == INHIBIT) || (state_q == REQ);
    assign ps_dat_oe = (state_q == REQ) || ((state_q == SHIFT) && dat_oe_q && !expire);
    assign ready     = (state_q == IDLE);
    assign busy      = ~ready;

endmodule
